rps_reset_sequencer: RTL
========================

Name: rps_reset_sequencer

Overview:
- Reset-domain controller: takes the board-level asynchronous reset and releases NUM_STAGES downstream reset outputs in a fixed order, with programmable spacing between releases.
- Also arbitrates a soft-reset request, using a request/acknowledge handshake to re-run the whole sequence.
- Sits between the clock/reset source and the datapath blocks, so that fabric, buffers and cores leave reset in order.

Parameters:
- NUM_STAGES, 4, number of sequenced reset outputs (≥1); stage 0 releases first.
- RESET_HOLD, 4, cycles held after synchronized reset release before stage 0 releases (≥1).
- STAGE_DELAY, 16, cycles between consecutive stage releases (≥1).
- SOFT_HOLD, 8, cycles all outputs are held asserted after a soft reset is accepted (≥1).
- SYNC_STAGES, 2, flops in the reset-deassertion synchronizer (≥2).
- ACTIVE_RESET, 1'b1, asserted level of rst_out bits.

Ports:
- clk, input, 1: single clock; all logic on rising edge.
- rst, input, 1: asynchronous, active-low reset.
- soft_req, input, 1: level soft-reset request.
- soft_ack, output, 1: one-cycle pulse when soft_req is accepted.
- rst_out, output, NUM_STAGES: per-stage reset; bit k is asserted at level ACTIVE_RESET.
- done, output, 1: high when all stages are released (state RUN).
- state, output, 2: FSM state, for debug (HOLD=0, RELEASE=1, RUN=2, SOFT=3).

Behaviour:
- rst low: asynchronously, without a clock edge, forces:
  - rst_out all ACTIVE_RESET, done=0, soft_ack=0
  - state=HOLD, counter=0, stage index=0
  - synchronizer cleared
- Deassertion synchronizer: after rst rises, internal reset stays active until SYNC_STAGES rising edges have passed.
  - Edge 0 is defined as the first rising edge at which the synchronized reset is inactive (the SYNC_STAGES-th edge after rst rises).
- All outputs are registered and glitch-free; each rst_out bit changes only on a clk edge, except for asynchronous assertion by rst.
- HOLD: counter counts edges. At edge RESET_HOLD: rst_out[0] deasserts, counter=0, state=RELEASE.
- RELEASE: stage k (k≥1) deasserts STAGE_DELAY edges after stage k-1.
  - rst_out[k] deasserts at edge RESET_HOLD + k*STAGE_DELAY.
  - On release of the last stage, at that same edge: state=RUN, done=1.
  - NUM_STAGES=1: HOLD goes straight to RUN at edge RESET_HOLD.
- Released stages stay released; the release order is never violated (rst_out[j] is deasserted whenever any higher-index bit is deasserted).
- RUN: soft_req is sampled every edge. If high at edge T:
  - After T: state=SOFT, all rst_out assert, done=0, soft_ack=1 for exactly one cycle.
- SOFT: at edge T+SOFT_HOLD, rst_out[0] deasserts and state=RELEASE; release then proceeds with STAGE_DELAY spacing as above.
- soft_req in HOLD, RELEASE or SOFT is ignored: no ack, no latching.
- The requester must drop soft_req after the ack. A request still high when RUN is re-entered is accepted again.
- rst asserted mid-sequence or in SOFT: immediate asynchronous abort to HOLD; the full sequence restarts from edge 0 after the next deassertion.
- Counter width: $clog2(max(RESET_HOLD, STAGE_DELAY, SOFT_HOLD)+1); no wrap occurs within legal parameters.

Test Plan:
- Defaults, rst low 3 cycles then high → rst_out=1111 until edge 4; 1110 @4, 1100 @20, 1000 @36, 0000 with done=1 and state=2 @52.
- In RUN, one-cycle soft_req at edge T → soft_ack=1 for one cycle, rst_out=1111, done=0, state=3; 1110 @T+8, 1100 @T+24, 1000 @T+40, 0000 and done @T+56.
- soft_req held high at edges 10–30 (HOLD/RELEASE) → no soft_ack, release times unchanged from the first scenario.
- rst driven low between edges 25 and 26 (rst_out=1100) → rst_out=1111 immediately, before the next edge; after rst rises, sequence restarts and done is reached at new edge 52.
- NUM_STAGES=1, STAGE_DELAY=1, RESET_HOLD=1 → rst_out deasserts and done=1 at edge 1.
- ACTIVE_RESET=0 → rst_out=0000 in reset, 1111 at edge 52; timing identical to the first scenario.

Source files
------------

// File: rtl/rps_reset_sequencer.sv
// Reset-domain sequencer: synchronizes board reset release, then releases NUM_STAGES
// reset outputs in order with programmable spacing; a soft request re-runs the sequence.
module rps_reset_sequencer #(
   parameter int unsigned NUM_STAGES   = 4,
   parameter int unsigned RESET_HOLD   = 4,
   parameter int unsigned STAGE_DELAY  = 16,
   parameter int unsigned SOFT_HOLD    = 8,
   parameter int unsigned SYNC_STAGES  = 2,
   parameter logic        ACTIVE_RESET = 1'b1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  soft_req,
   output logic                  soft_ack,
   output logic [NUM_STAGES-1:0] rst_out,
   output logic                  done,
   output logic [1:0]            state
);

   typedef enum logic [1:0] {
      ST_HOLD    = 2'd0,
      ST_RELEASE = 2'd1,
      ST_RUN     = 2'd2,
      ST_SOFT    = 2'd3
   } state_t;

   localparam int unsigned MAX_HS  = (RESET_HOLD > STAGE_DELAY) ? RESET_HOLD : STAGE_DELAY;
   localparam int unsigned CNT_MAX = (MAX_HS > SOFT_HOLD) ? MAX_HS : SOFT_HOLD;
   localparam int unsigned CW      = $clog2(CNT_MAX + 1);
   localparam int unsigned IW      = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1;

   localparam logic [CW-1:0] HOLD_LAST  = CW'(RESET_HOLD - 1);
   localparam logic [CW-1:0] STAGE_LAST = CW'(STAGE_DELAY - 1);
   localparam logic [CW-1:0] SOFT_LAST  = CW'(SOFT_HOLD - 1);
   localparam logic [IW-1:0] IDX_LAST   = IW'(NUM_STAGES - 1);

   logic [SYNC_STAGES-1:0] sync_q;
   logic [SYNC_STAGES-1:0] sync_d;
   logic                   run_en;

   state_t                 state_q;
   logic [CW-1:0]          cnt_q;
   logic [CW-1:0]          cnt_d;
   logic [IW-1:0]          idx_q;
   logic [IW-1:0]          idx_d;
   logic [NUM_STAGES-1:0]  rst_out_q;
   logic                   done_q;
   logic                   soft_ack_q;
   logic                   fire;
   logic                   last_stage;

   assign sync_d = {sync_q[SYNC_STAGES-2:0], 1'b1};
   assign run_en = sync_q[SYNC_STAGES-1];

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sync_q <= '0;
      end else begin
         sync_q <= sync_d;
      end
   end

   assign cnt_d      = cnt_q + 1'b1;
   assign idx_d      = idx_q + 1'b1;
   assign last_stage = (idx_q == IDX_LAST);

   // HOLD and SOFT always release stage 0 because idx_q is zeroed on entry to both.
   always_comb begin
      fire = 1'b0;
      case (state_q)
         ST_HOLD:    fire = (cnt_q == HOLD_LAST);
         ST_RELEASE: fire = (cnt_q == STAGE_LAST);
         ST_SOFT:    fire = (cnt_q == SOFT_LAST);
         default:    fire = 1'b0;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= ST_HOLD;
         cnt_q      <= '0;
         idx_q      <= '0;
         rst_out_q  <= {NUM_STAGES{ACTIVE_RESET}};
         done_q     <= 1'b0;
         soft_ack_q <= 1'b0;
      end else if (run_en) begin
         case (state_q)
            ST_HOLD, ST_RELEASE, ST_SOFT: begin
               soft_ack_q <= 1'b0;
               if (fire) begin
                  for (int unsigned k = 0; k < NUM_STAGES; k++) begin
                     if (IW'(k) == idx_q) begin
                        rst_out_q[k] <= ~ACTIVE_RESET;
                     end
                  end
                  cnt_q <= '0;
                  if (last_stage) begin
                     state_q <= ST_RUN;
                     done_q  <= 1'b1;
                  end else begin
                     state_q <= ST_RELEASE;
                     idx_q   <= idx_d;
                  end
               end else begin
                  cnt_q <= cnt_d;
               end
            end
            ST_RUN: begin
               if (soft_req) begin
                  state_q    <= ST_SOFT;
                  rst_out_q  <= {NUM_STAGES{ACTIVE_RESET}};
                  done_q     <= 1'b0;
                  soft_ack_q <= 1'b1;
                  cnt_q      <= '0;
                  idx_q      <= '0;
               end else begin
                  soft_ack_q <= 1'b0;
               end
            end
            default: begin
               state_q <= ST_HOLD;
            end
         endcase
      end
   end

   assign rst_out  = rst_out_q;
   assign done     = done_q;
   assign soft_ack = soft_ack_q;
   assign state    = state_q;

endmodule
